// File: rtl/char_tile_display.sv
`default_nettype none
// ============================================================================
// char_tile_display : COLS x ROWS character-cell renderer with 2-clk pixel
//                     pipeline, host write port and optional blinking cursor
//                     (enable with `define CHAR_CURSOR_EN).
// Revision          : 1.0
// ============================================================================
module char_tile_display #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 60,
    parameter int         CELL_SHIFT   = 3,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter int         BLINK_FRAMES = 30,
    parameter int         AW           = 14
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   hpos,
    input  logic [10:0]   vpos,
    input  logic          display_on,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_drop,
    input  logic [AW-1:0] cursor_addr,
    output logic [2:0]    rgb,
    output logic          hsync,
    output logic          vsync
);
    localparam int          DEPTH     = COLS * ROWS;
    localparam int          RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] CELL_MASK = 11'((1 << CELL_SHIFT) - 1);

    function automatic logic [63:0] glyph_bits(input logic [3:0] g);
        case (g)
            4'd0:    glyph_bits = 64'h3C66_6E76_6666_3C00;
            4'd1:    glyph_bits = 64'h1838_1818_1818_7E00;
            4'd2:    glyph_bits = 64'h3C66_060C_3060_7E00;
            4'd3:    glyph_bits = 64'h3C66_061C_0666_3C00;
            4'd4:    glyph_bits = 64'h0C1C_3C6C_7E0C_0C00;
            4'd5:    glyph_bits = 64'h7E60_7C06_0666_3C00;
            4'd6:    glyph_bits = 64'h3C60_7C66_6666_3C00;
            4'd7:    glyph_bits = 64'h7E06_0C18_3030_3000;
            4'd8:    glyph_bits = 64'h3C66_663C_6666_3C00;
            4'd9:    glyph_bits = 64'h3C66_663E_060C_3800;
            default: glyph_bits = 64'h0;
        endcase
    endfunction

    logic [10:0]       w_col, w_row, w_xoff, w_yoff;
    logic [2:0]        w_gx, w_gy;
    logic              w_in_grid;
    logic [AW-1:0]     row_base_q, row_base_d, w_rd_addr;
    logic [10:0]       prev_row_q;
    logic              w_wr_fire, w_wr_oob, w_we, w_cursor_hit;
    logic [RAM_AW-1:0] w_port_addr;
    logic [7:0]        mem [0:(1 << RAM_AW) - 1];

    logic [7:0]        cell_q;
    logic [2:0]        gx_q, gy_q;
    logic              in_grid_q, cursor_hit_q, de1_q, wr_drop_q;
    logic [1:0]        hs_q, vs_q;
    logic [2:0]        rgb_q, rgb_d;
    logic [63:0]       w_glyph;
    logic [7:0]        w_font_row;
    logic              w_pix_on;

    assign w_col  = hpos >> CELL_SHIFT;
    assign w_row  = vpos >> CELL_SHIFT;
    assign w_xoff = hpos & CELL_MASK;
    assign w_yoff = vpos & CELL_MASK;
    // Top three bits of the in-cell offset; large cells replicate glyph pixels.
    assign w_gx = 3'(({3'b000, w_xoff} << 3) >> CELL_SHIFT);
    assign w_gy = 3'(({3'b000, w_yoff} << 3) >> CELL_SHIFT);
    assign w_in_grid = (32'(w_col) < COLS) && (32'(w_row) < ROWS);

    always_comb begin
        row_base_d = row_base_q;
        if (vpos == 11'd0) begin
            row_base_d = '0;
        end else if (w_row != prev_row_q) begin
            row_base_d = row_base_q + AW'(COLS);
        end
    end

    assign w_rd_addr = row_base_d + AW'(w_col);

    assign wr_ready    = reset_n & ~display_on;
    assign w_wr_fire   = wr_valid & wr_ready;
    assign w_wr_oob    = ({1'b0, wr_addr} >= (AW + 1)'(DEPTH));
    assign w_we        = w_wr_fire & ~w_wr_oob;
    assign w_port_addr = display_on ? RAM_AW'(w_rd_addr) : RAM_AW'(wr_addr);

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_port_addr] <= wr_data;
        end
    end

`ifdef CHAR_CURSOR_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           blink_q, blink_d, vs_prev_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (vsync_in && !vs_prev_q) begin
            if (32'(frame_cnt_q) + 32'd1 >= 32'(BLINK_FRAMES)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            vs_prev_q   <= vsync_in;
        end
    end

    assign w_cursor_hit = blink_q && (w_rd_addr == cursor_addr);
`else
    logic w_unused_cursor;
    assign w_unused_cursor = (^cursor_addr) ^ (BLINK_FRAMES > 0);
    assign w_cursor_hit    = 1'b0;
`endif

    // Stage 2: glyph row select and fg/bg mux.
    assign w_glyph    = glyph_bits(cell_q[3:0]);
    assign w_font_row = 8'(w_glyph >> {3'd7 - gy_q, 3'b000});
    assign w_pix_on   = w_font_row[3'd7 - gx_q];

    always_comb begin
        rgb_d = 3'b000;
        if (de1_q) begin
            if (in_grid_q && (w_pix_on ^ cell_q[7] ^ cursor_hit_q)) begin
                rgb_d = cell_q[6:4];
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base_q   <= '0;
            prev_row_q   <= '0;
            cell_q       <= '0;
            gx_q         <= '0;
            gy_q         <= '0;
            in_grid_q    <= 1'b0;
            cursor_hit_q <= 1'b0;
            de1_q        <= 1'b0;
            hs_q         <= '0;
            vs_q         <= '0;
            rgb_q        <= '0;
            wr_drop_q    <= 1'b0;
        end else begin
            row_base_q   <= row_base_d;
            prev_row_q   <= w_row;
            cell_q       <= mem[w_port_addr];
            gx_q         <= w_gx;
            gy_q         <= w_gy;
            in_grid_q    <= w_in_grid;
            cursor_hit_q <= w_cursor_hit;
            de1_q        <= display_on;
            hs_q         <= {hs_q[0], hsync_in};
            vs_q         <= {vs_q[0], vsync_in};
            rgb_q        <= rgb_d;
            wr_drop_q    <= w_wr_fire & w_wr_oob;
        end
    end

    assign rgb     = rgb_q;
    assign hsync   = hs_q[1];
    assign vsync   = vs_q[1];
    assign wr_drop = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_char_tile_display.sv
`default_nettype none
// tb_char_tile_display : directed checks of char_tile_display on a reduced
// 32x20 raster (3x2 visible cells), BG_COLOR=3'b100 so background is visible.
module tb_char_tile_display;
    localparam logic [2:0] BG = 3'b100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hpos, vpos;
    logic        display_on, hsync_in, vsync_in;
    logic        wr_valid, wr_ready, wr_drop;
    logic [13:0] wr_addr, cursor_addr;
    logic [7:0]  wr_data;
    logic [2:0]  rgb;
    logic        hsync, vsync;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] cap_rgb [0:19][0:31];
    logic       cap_hs  [0:19][0:31];

    always #5 clk = ~clk;

    char_tile_display #(
        .COLS(80), .ROWS(60), .CELL_SHIFT(3), .BG_COLOR(BG),
        .BLINK_FRAMES(2), .AW(14)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_drop(wr_drop), .cursor_addr(cursor_addr),
        .rgb(rgb), .hsync(hsync), .vsync(vsync)
    );

    task automatic idle();
        hpos = '0; vpos = '0; display_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d);
        display_on = 1'b0; wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    // Sweep one mini frame; each sample holds the pixel driven two edges earlier.
    task automatic render_frame();
        int ph = 0;
        int pv = 0;
        for (int v = 0; v < 20; v++) begin
            for (int h = 0; h < 32; h++) begin
                hpos = 11'(h); vpos = 11'(v);
                display_on = (v < 16) && (h < 24);
                hsync_in   = (h >= 26) && (h < 29);
                vsync_in   = (v == 17) || (v == 18);
                step();
                if (v != 0 || h != 0) begin
                    cap_rgb[pv][ph] = rgb; cap_hs[pv][ph] = hsync;
                end
                pv = v; ph = h;
            end
        end
        idle();
        step();
        cap_rgb[pv][ph] = rgb; cap_hs[pv][ph] = hsync;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle(); wr_addr = '0; wr_data = '0; cursor_addr = 14'd5000;
        repeat (3) step();
        n_cmp++; if (rgb !== 3'b000) begin n_err++; $display("FAIL rst_rgb: got %b want 000", rgb); end
        n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL rst_hsync: got %b want 0", hsync); end
        n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL rst_vsync: got %b want 0", vsync); end
        n_cmp++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", wr_drop); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", wr_ready); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", wr_ready); end
        step();
    endtask

    task automatic test_first_write();
        do_write(14'd1, 8'h0A);  do_write(14'd2, 8'hFA);  do_write(14'd3, 8'hFA);
        do_write(14'd80, 8'h0A); do_write(14'd81, 8'h0A); do_write(14'd82, 8'h0A);
        do_write(14'd0, 8'h23);
        hpos = 11'd2; vpos = 11'd0; display_on = 1'b1;
        step();
        n_cmp++; if (rgb !== 3'b000) begin n_err++; $display("FAIL lat_1clk: got %b want 000", rgb); end
        hpos = 11'd1;
        step();
        n_cmp++; if (rgb !== 3'b010) begin n_err++; $display("FAIL lat_2clk: got %b want 010", rgb); end
        idle();
        step();
        n_cmp++; if (rgb !== BG) begin n_err++; $display("FAIL lat_next: got %b want %b", rgb, BG); end
        render_frame();
        n_cmp++; if (cap_rgb[0][2] !== 3'b010) begin n_err++; $display("FAIL g3_r0x2: got %b want 010", cap_rgb[0][2]); end
        n_cmp++; if (cap_rgb[0][1] !== BG) begin n_err++; $display("FAIL g3_r0x1: got %b want %b", cap_rgb[0][1], BG); end
        n_cmp++; if (cap_rgb[3][3] !== 3'b010) begin n_err++; $display("FAIL g3_r3x3: got %b want 010", cap_rgb[3][3]); end
        n_cmp++; if (cap_rgb[3][2] !== BG) begin n_err++; $display("FAIL g3_r3x2: got %b want %b", cap_rgb[3][2], BG); end
        n_cmp++; if (cap_rgb[0][16] !== 3'b111) begin n_err++; $display("FAIL blank_inv: got %b want 111", cap_rgb[0][16]); end
        n_cmp++; if (cap_rgb[0][24] !== 3'b000) begin n_err++; $display("FAIL de_off: got %b want 000", cap_rgb[0][24]); end
        n_cmp++; if (cap_hs[0][25] !== 1'b0) begin n_err++; $display("FAIL hs_pre: got %b want 0", cap_hs[0][25]); end
        n_cmp++; if (cap_hs[0][26] !== 1'b1) begin n_err++; $display("FAIL hs_align: got %b want 1", cap_hs[0][26]); end
        n_cmp++; if (cap_hs[0][29] !== 1'b0) begin n_err++; $display("FAIL hs_end: got %b want 0", cap_hs[0][29]); end
    endtask

    task automatic test_write_hold();
        hpos = 11'd0; vpos = 11'd0; display_on = 1'b1;
        wr_valid = 1'b1; wr_addr = 14'd1; wr_data = 8'h17;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready: got %b want 0", wr_ready); end
        step();
        idle();
        step();
        render_frame();
        n_cmp++; if (cap_rgb[0][9] !== BG) begin n_err++; $display("FAIL hold_nowrite: got %b want %b", cap_rgb[0][9], BG); end
        wr_valid = 1'b1; wr_addr = 14'd1; wr_data = 8'h17; display_on = 1'b0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL retry_ready: got %b want 1", wr_ready); end
        step();
        wr_valid = 1'b0; hpos = 11'd9; vpos = 11'd0; display_on = 1'b1;
        step();
        idle();
        step();
        n_cmp++; if (rgb !== 3'b001) begin n_err++; $display("FAIL wr_visible: got %b want 001", rgb); end
    endtask

    task automatic test_drop();
        display_on = 1'b0; wr_valid = 1'b1; wr_addr = 14'd4800; wr_data = 8'h7E;
        #1;
        n_cmp++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_pre: got %b want 0", wr_drop); end
        step();
        wr_valid = 1'b0;
        n_cmp++; if (wr_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b want 1", wr_drop); end
        step();
        n_cmp++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_once: got %b want 0", wr_drop); end
        do_write(14'd4799, 8'h0A);
        n_cmp++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_inrange: got %b want 0", wr_drop); end
        render_frame();
        n_cmp++; if (cap_rgb[0][2] !== 3'b010) begin n_err++; $display("FAIL drop_cell0: got %b want 010", cap_rgb[0][2]); end
        n_cmp++; if (cap_rgb[0][9] !== 3'b001) begin n_err++; $display("FAIL drop_cell1: got %b want 001", cap_rgb[0][9]); end
        n_cmp++; if (cap_rgb[0][16] !== 3'b111) begin n_err++; $display("FAIL drop_cell2: got %b want 111", cap_rgb[0][16]); end
    endtask

    task automatic test_inverse();
        do_write(14'd81, 8'hA5);
        render_frame();
        n_cmp++; if (cap_rgb[8][8] !== 3'b010) begin n_err++; $display("FAIL inv_r0x0: got %b want 010", cap_rgb[8][8]); end
        n_cmp++; if (cap_rgb[8][9] !== BG) begin n_err++; $display("FAIL inv_r0x1: got %b want %b", cap_rgb[8][9], BG); end
        n_cmp++; if (cap_rgb[9][11] !== 3'b010) begin n_err++; $display("FAIL inv_r1x3: got %b want 010", cap_rgb[9][11]); end
        n_cmp++; if (cap_rgb[9][9] !== BG) begin n_err++; $display("FAIL inv_r1x1: got %b want %b", cap_rgb[9][9], BG); end
        n_cmp++; if (cap_rgb[8][0] !== BG) begin n_err++; $display("FAIL row1_col0: got %b want %b", cap_rgb[8][0], BG); end
        hpos = 11'd640; vpos = 11'd0; display_on = 1'b1;
        step();
        idle();
        step();
        n_cmp++; if (rgb !== BG) begin n_err++; $display("FAIL col_oob: got %b want %b", rgb, BG); end
        hpos = 11'd0; vpos = 11'd480; display_on = 1'b1;
        step();
        idle();
        step();
        n_cmp++; if (rgb !== BG) begin n_err++; $display("FAIL row_oob: got %b want %b", rgb, BG); end
    endtask

    task automatic test_reset_midline();
        hpos = 11'd2; vpos = 11'd0; display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        step();
        step();
        n_cmp++; if (rgb !== 3'b010) begin n_err++; $display("FAIL pre_rst_rgb: got %b want 010", rgb); end
        n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL pre_rst_hs: got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL pre_rst_vs: got %b want 1", vsync); end
        display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (rgb !== 3'b000) begin n_err++; $display("FAIL async_rgb: got %b want 000", rgb); end
        n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL async_hs: got %b want 0", hsync); end
        n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL async_vs: got %b want 0", vsync); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", wr_ready); end
        step();
        reset_n = 1'b1; idle();
        step();
        render_frame();
        n_cmp++; if (cap_rgb[0][2] !== 3'b010) begin n_err++; $display("FAIL resume_r0: got %b want 010", cap_rgb[0][2]); end
        n_cmp++; if (cap_rgb[9][11] !== 3'b010) begin n_err++; $display("FAIL resume_r1: got %b want 010", cap_rgb[9][11]); end
    endtask

    task automatic test_blink();
        logic [5:0] inv_tbl;
        logic [2:0] exp_on, exp_off;
`ifdef CHAR_CURSOR_EN
        inv_tbl = 6'b001100;
`else
        inv_tbl = 6'b000000;
`endif
        idle(); cursor_addr = 14'd0; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int f = 0; f < 6; f++) begin
            render_frame();
            exp_on  = inv_tbl[f] ? BG : 3'b010;
            exp_off = inv_tbl[f] ? 3'b010 : BG;
            n_cmp++; if (cap_rgb[0][2] !== exp_on) begin n_err++; $display("FAIL blink_on f%0d: got %b want %b", f, cap_rgb[0][2], exp_on); end
            n_cmp++; if (cap_rgb[0][0] !== exp_off) begin n_err++; $display("FAIL blink_off f%0d: got %b want %b", f, cap_rgb[0][0], exp_off); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_write();
        test_write_hold();
        test_drop();
        test_inverse();
        test_reset_midline();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/char_tile_display.md
# char_tile_display

Parametrised character-cell display engine that sits between the VGA sync generator and the pins. It renders a COLS×ROWS grid of 8×8-style glyph cells from an internal byte RAM, with per-cell colour and inverse video. A host-side valid/ready write port updates the RAM during blanking. Syncs are pipeline-aligned, and an optional blinking cursor is supported.

## Interface
- COLS, 80, cells per row (1..128)
- ROWS, 60, cell rows (1..128)
- CELL_SHIFT, 3, log2 of cell width/height in pixels (cells are 2^CELL_SHIFT square)
- BG_COLOR, 3'b000, {b,g,r} background colour
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)
- AW, 14, RAM address width; COLS*ROWS ≤ 2^AW
- clk  in  1  pixel clock (px_clk from sync generator)
- reset_n  in  1  asynchronous, active-low reset
- hpos  in  11  pixel column from sync generator
- vpos  in  11  pixel row from sync generator
- display_on  in  1  active-video flag
- hsync_in, vsync_in  in  1 each  raw syncs from sync generator
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle when wr_valid&&wr_ready
- wr_addr  in  AW  linear cell index, row*COLS+col
- wr_data  in  8  cell byte
- wr_drop  out  1  one-cycle pulse when an accepted write had wr_addr ≥ COLS*ROWS
- cursor_addr  in  AW  linear cell index of the cursor
- rgb  out  3  {b,g,r} pixel
- hsync, vsync  out  1 each  syncs delayed to align with rgb

## Operation
- Cell byte: [3:0] glyph (0–9 = digit glyphs, 10–15 = blank); [6:4] foreground {b,g,r}; [7] inverse (swap fg/BG_COLOR).
- col = hpos>>CELL_SHIFT, row = vpos>>CELL_SHIFT. Pixels with col≥COLS or row≥ROWS, or with display_on=0, output BG_COLOR (display_on=0 forces rgb=0).
- Linear address without multiplier: row_base register reset to 0 at vpos==0, incremented by COLS when vpos crosses a cell boundary. Address = row_base+col.
- Glyph scaling: glyph bit index uses the top 3 bits of the in-cell offset, so cells larger than 8 px replicate pixels.
- Single-port RAM, one access per cycle. Display read owns the port while display_on=1.
- Write port: wr_ready = reset released && display_on=0. An accepted write is performed that cycle. If wr_addr ≥ COLS*ROWS, the RAM is unchanged and wr_drop pulses next cycle.
- Blink: a frame counter increments on each vsync_in rising edge. At BLINK_FRAMES it wraps to 0 and toggles blink_phase.

## Timing
- Pipeline latency: 2 clk from hpos/vpos/display_on/syncs to rgb/hsync/vsync.
  - Stage 1: RAM read.
  - Stage 2: glyph decode and colour mux, registered.
- Syncs and display_on are delayed through an identical 2-stage shift register.
- wr_ready is combinational from display_on and the reset state.
- A write accepted at cycle t is visible to a display read from cycle t+1.
- Reset values: rgb=0, hsync=0, vsync=0, wr_drop=0, wr_ready=0, row_base=0, frame counter=0, blink_phase=0, pipeline regs=0. RAM contents are not reset.
- Reset mid-frame: outputs go to 0 immediately (async). On release, rendering resumes at the next pixel. Row_base is undefined until the next vpos==0, so that frame's rows are undefined.
- Simultaneous wr_valid and display_on rising edge: the write is not accepted and wr_valid must be held.

## Configuration
- CHAR_CURSOR_EN defined: the cell at cursor_addr is rendered with inverse toggled while blink_phase=1. The frame counter and blink_phase are implemented.
- CHAR_CURSOR_EN undefined: cursor_addr is ignored, and the frame counter and blink_phase are not synthesised. Rendering is otherwise identical.

## Test plan
- Reset, then release with COLS=80, ROWS=60; write 8'h23 to address 0 in blanking → cell (0,0) shows glyph 3 in green (3'b010) from the first active pixel, with rgb appearing 2 clk after hpos=0 and aligned with hsync.
- Hold wr_valid across the display_on 0→1 edge → wr_ready drops that cycle, no write occurs, and the write completes at the next blanking.
- Write wr_addr=4800 (=COLS*ROWS) → wr_drop pulses once and no RAM cell changes.
- Write 8'hA5 to address 81 → the cell at row 1, col 1 shows inverse glyph 5: background 3'b010, glyph pixels BG_COLOR.
- With CHAR_CURSOR_EN, BLINK_FRAMES=2, cursor_addr=0 → cell 0 inverts on frames 2–3 and is normal on frames 0–1 and 4–5. Without the macro, cell 0 never inverts.
- Assert reset_n low mid-line → rgb/hsync/vsync go to 0 within the same cycle, wr_ready=0, and correct rendering resumes from the next frame.
